chord_voice_allocator: RTL and testbench
========================================

# chord_voice_allocator

Scheduler between the song reader and the bank of note players in the chord player. Accepts a stream of note and advance events over a valid/ready handshake and assigns each note to a free voice with round-robin priority. Tracks per-voice busy state from the players' done pulses. Holds the stream during advance (time-step) events until the requested number of beats has elapsed.

## Interface
- NUM_VOICES, 3, number of note players driven (2..8)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beats
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- play  in  1  1 = run; 0 = freeze dispatch and beat counting
- beat  in  1  one-cycle beat strobe
- ev_valid  in  1  event present
- ev_ready  out  1  event accepted this cycle when ev_valid && ev_ready
- ev_advance  in  1  1 = advance event (wait ev_duration beats), 0 = note event
- ev_note  in  NOTE_W  note code (note events)
- ev_duration  in  DUR_W  note duration or advance length in beats
- voice_done  in  NUM_VOICES  per-voice done_with_note pulses
- note_to_load  out  NUM_VOICES*NOTE_W  per-voice note, voice i at bits [i*NOTE_W +: NOTE_W]
- duration_to_load  out  NUM_VOICES*DUR_W  per-voice duration, same packing
- load_new_note  out  NUM_VOICES  one-hot, one-cycle load pulse
- voice_busy  out  NUM_VOICES  voice currently holds a note
- all_idle  out  1  no voice busy, FSM in DISPATCH, no event pending

## Operation
- States: DISPATCH, WAIT_FREE, ADVANCE.
- DISPATCH, play=1:
  - ev_ready=1 if the event is an advance, or if any voice is free.
  - Accepted note goes to the first free voice at or after rr_ptr, wrapping modulo NUM_VOICES.
  - rr_ptr moves to (chosen+1) mod NUM_VOICES.
- DISPATCH, note event with all voices busy:
  - ev_ready=0, go to WAIT_FREE.
- WAIT_FREE:
  - ev_ready=1 as soon as any voice is free (combinational on voice_busy), allocate as above, return to DISPATCH.
- Accepted advance, ev_duration=0: no wait, stay in DISPATCH.
- Accepted advance, ev_duration>0: load beat_cnt=ev_duration, go to ADVANCE with ev_ready=0.
  - Each beat with play=1 decrements beat_cnt.
  - On the beat that makes beat_cnt 0, return to DISPATCH; ev_ready may be 1 the following cycle.
- play=0: ev_ready=0, beats ignored, state and counters held. No loads issued.
- busy[i]:
  - Set in the cycle load_new_note[i] pulses; cleared on voice_done[i].
  - Simultaneous load and done on the same voice: load wins, busy stays 1.
  - voice_done on an idle voice is ignored.
- note_to_load/duration_to_load for voice i are registered at acceptance and held until that voice's next load.

## Timing
- Reset values:
  - state=DISPATCH, rr_ptr=0, beat_cnt=0, busy=0.
  - note_to_load=0, duration_to_load=0, load_new_note=0.
  - ev_ready=0 while reset is asserted; all_idle=1 after reset.
- Latency:
  - Acceptance at edge N → load_new_note and data valid in cycle N+1, busy[i]=1 from N+1.
  - At most one acceptance per cycle.
- Advance of D beats: ev_ready is low from the acceptance edge until the cycle after the D-th qualifying beat.
- A beat coinciding with the advance acceptance edge does not count.
- Reset mid-advance or mid-wait aborts immediately. Voices are marked free; the players are reset by the same signal.
- ev_* must be held stable while ev_valid=1 and ev_ready=0.

## Configuration
- VOICE_STEAL_EN defined:
  - A note event with all voices busy is accepted immediately in DISPATCH.
  - It overwrites the voice at rr_ptr (oldest allocation) with a fresh load pulse; rr_ptr advances.
  - WAIT_FREE is unreachable.
- Undefined: stall via WAIT_FREE as described.

## Test plan
- Reset, then three notes (10,4),(14,4),(17,4) back-to-back, NUM_VOICES=3 → load_new_note 001,010,100 on consecutive cycles; voice_busy=111; note_to_load fields 10,14,17.
- All busy, fourth note 20 offered → ev_ready=0 (stall); voice_done=010 → next cycle ev_ready=1, voice 1 loads 20.
- Advance D=3, beats every 8 cycles → ev_ready low until the cycle after the third beat; D=0 → ev_ready stays 1, no stall.
- play dropped for 2 beats mid-advance D=2 → those beats ignored; completes after 2 beats once play=1.
- voice_done[0] and load to voice 0 in the same cycle → voice_busy[0] stays 1; done on idle voice 2 → no change.
- VOICE_STEAL_EN, all busy, rr_ptr=0, note 30 → accepted without stall, load_new_note=001, note_to_load[0]=30, rr_ptr=1.

Source files
------------

// File: rtl/chord_voice_allocator_if.sv
// Event stream from the song reader into the voice allocator:
// note/advance events over a valid/ready handshake.
interface chord_voice_allocator_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_advance;
    logic [NOTE_W-1:0] ev_note;
    logic [DUR_W-1:0]  ev_duration;

    modport master (
        output ev_valid, ev_advance, ev_note, ev_duration,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_advance, ev_note, ev_duration,
        output ev_ready
    );
endinterface

// File: rtl/chord_voice_allocator.sv
// Round-robin note-to-voice scheduler with beat-timed advance events.
// Optional VOICE_STEAL_EN: steal the voice at rr_ptr instead of stalling when all are busy.
module chord_voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         beat,
    chord_voice_allocator_if.slave       ev,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES*NOTE_W-1:0] note_to_load,
    output logic [NUM_VOICES*DUR_W-1:0]  duration_to_load,
    output logic [NUM_VOICES-1:0]        load_new_note,
    output logic [NUM_VOICES-1:0]        voice_busy,
    output logic                         all_idle
);
    localparam int PTR_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {DISPATCH, WAIT_FREE, ADVANCE} state_t;

    state_t                state, state_nx;
    logic [PTR_W-1:0]      rr_ptr, rr_ptr_nx;
    logic [DUR_W-1:0]      beat_cnt, beat_cnt_nx;
    logic [NUM_VOICES-1:0] busy;
    logic [NUM_VOICES-1:0] alloc_vec;
    logic [PTR_W-1:0]      chosen;
    logic                  any_free;
    logic                  ready_c;
    logic                  alloc;

    // First free voice at or after start, wrapping; returns start when none is free,
    // which is exactly the steal target.
    function automatic logic [PTR_W-1:0] pick_free(input logic [NUM_VOICES-1:0] free_mask,
                                                    input logic [PTR_W-1:0]      start);
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] cand;
        logic             found;
        int               idx;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
            cand = PTR_W'(idx);
            if (!found && free_mask[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_VOICES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign any_free  = ~&busy;
    assign chosen    = pick_free(~busy, rr_ptr);
    assign alloc_vec = alloc ? (NUM_VOICES'(1) << chosen) : '0;

    always_comb begin
        state_nx    = state;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        ready_c     = 1'b0;
        alloc       = 1'b0;
        case (state)
            DISPATCH: begin
                if (play) begin
                    if (ev.ev_advance) begin
                        ready_c = 1'b1;
                        if (ev.ev_valid && (ev.ev_duration != '0)) begin
                            state_nx    = ADVANCE;
                            beat_cnt_nx = ev.ev_duration;
                        end
                    end else if (any_free) begin
                        ready_c = 1'b1;
                        alloc   = ev.ev_valid;
                    end else begin
`ifdef VOICE_STEAL_EN
                        ready_c = 1'b1;
                        alloc   = ev.ev_valid;
`else
                        if (ev.ev_valid) state_nx = WAIT_FREE;
`endif
                    end
                end
            end
            WAIT_FREE: begin
                if (play) begin
                    if (!ev.ev_valid) begin
                        state_nx = DISPATCH;
                    end else if (any_free) begin
                        ready_c  = 1'b1;
                        alloc    = 1'b1;
                        state_nx = DISPATCH;
                    end
                end
            end
            ADVANCE: begin
                if (play && beat) begin
                    beat_cnt_nx = beat_cnt - DUR_W'(1);
                    if (beat_cnt == DUR_W'(1)) state_nx = DISPATCH;
                end
            end
            default: state_nx = DISPATCH;
        endcase
        if (alloc) rr_ptr_nx = next_ptr(chosen);
    end

    // Ready is forced low for as long as reset is held, not just from the next edge.
    assign ev.ev_ready = ready_c & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= DISPATCH;
            rr_ptr           <= '0;
            beat_cnt         <= '0;
            busy             <= '0;
            load_new_note    <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
        end else begin
            state         <= state_nx;
            rr_ptr        <= rr_ptr_nx;
            beat_cnt      <= beat_cnt_nx;
            load_new_note <= alloc_vec;
            // A done pulse overlapping a load pulse belongs to the previous note and is dropped.
            busy          <= (busy & ~(voice_done & ~load_new_note)) | alloc_vec;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (alloc_vec[i]) begin
                    note_to_load[i*NOTE_W +: NOTE_W]    <= ev.ev_note;
                    duration_to_load[i*DUR_W +: DUR_W]  <= ev.ev_duration;
                end
            end
        end
    end

    assign voice_busy = busy;
    assign all_idle   = (busy == '0) && (state == DISPATCH) && !ev.ev_valid;

endmodule

// File: tb/tb_chord_voice_allocator.sv
// Directed bench for chord_voice_allocator (3 voices); steal path when VOICE_STEAL_EN is defined.
module tb_chord_voice_allocator;
    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic          beat;
    logic [NV-1:0] voice_done;
    logic [NV*NW-1:0] note_to_load;
    logic [NV*DW-1:0] duration_to_load;
    logic [NV-1:0] load_new_note;
    logic [NV-1:0] voice_busy;
    logic          all_idle;

    int n_checks = 0;
    int n_pass   = 0;

    chord_voice_allocator_if #(.NOTE_W(NW), .DUR_W(DW)) ev ();

    chord_voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .beat             (beat),
        .ev               (ev),
        .voice_done       (voice_done),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .voice_busy       (voice_busy),
        .all_idle         (all_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; play = 1'b0; beat = 1'b0; voice_done = '0;
        ev.ev_valid = 1'b0; ev.ev_advance = 1'b0; ev.ev_note = '0; ev.ev_duration = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ev.ev_ready, 0);
        check("rst_busy", voice_busy, 0);
        check("rst_load", load_new_note, 0);
        check("rst_notes", note_to_load, 0);
        reset = 1'b1; play = 1'b1;
        #1;
        check("idle_after_rst", all_idle, 1);

        // Three back-to-back notes fill voices 0,1,2
        ev.ev_valid = 1'b1; ev.ev_advance = 1'b0; ev.ev_note = 6'd10; ev.ev_duration = 6'd4;
        #1 check("ready_n1", ev.ev_ready, 1);
        tick();
        check("load_n1", load_new_note, 3'b001);
        check("note0", note_to_load[0*NW +: NW], 10);
        check("dur0", duration_to_load[0*DW +: DW], 4);
        ev.ev_note = 6'd14;
        tick();
        check("load_n2", load_new_note, 3'b010);
        check("note1", note_to_load[1*NW +: NW], 14);
        ev.ev_note = 6'd17;
        tick();
        check("load_n3", load_new_note, 3'b100);
        check("note2", note_to_load[2*NW +: NW], 17);
        check("busy_full", voice_busy, 3'b111);

`ifndef VOICE_STEAL_EN
        // Fourth note stalls until voice 1 reports done
        ev.ev_note = 6'd20;
        #1 check("stall_ready", ev.ev_ready, 0);
        tick();
        check("wait_ready", ev.ev_ready, 0);
        check("wait_noload", load_new_note, 0);
        voice_done = 3'b010;
        tick();
        voice_done = '0;
        check("busy_after_done", voice_busy, 3'b101);
        check("wait_release", ev.ev_ready, 1);
        tick();
        ev.ev_valid = 1'b0;
        check("load_n4", load_new_note, 3'b010);
        check("note1_n4", note_to_load[1*NW +: NW], 20);
        check("busy_n4", voice_busy, 3'b111);
`else
        // All busy: steal voice at rr_ptr=0, then voice 1
        ev.ev_note = 6'd30;
        #1 check("steal_ready", ev.ev_ready, 1);
        tick();
        check("steal_load", load_new_note, 3'b001);
        check("steal_note0", note_to_load[0*NW +: NW], 30);
        ev.ev_note = 6'd20;
        #1 check("steal2_ready", ev.ev_ready, 1);
        tick();
        ev.ev_valid = 1'b0;
        check("steal2_load", load_new_note, 3'b010);
        check("steal2_note1", note_to_load[1*NW +: NW], 20);
        check("steal_busy", voice_busy, 3'b111);
`endif

        // Done on voice 0 during an unrelated load pulse, then reload voice 0
        voice_done = 3'b001;
        tick();
        voice_done = '0;
        check("busy_free0", voice_busy, 3'b110);
        ev.ev_valid = 1'b1; ev.ev_note = 6'd25; ev.ev_duration = 6'd2;
        #1 check("ready_n5", ev.ev_ready, 1);
        tick();
        ev.ev_valid = 1'b0;
        check("load_n5", load_new_note, 3'b001);
        check("note0_n5", note_to_load[0*NW +: NW], 25);
        voice_done = 3'b001;
        tick();
        voice_done = '0;
        check("load_wins", voice_busy, 3'b111);

        // Done on an idle voice is ignored
        voice_done = 3'b100;
        tick();
        check("busy_free2", voice_busy, 3'b011);
        tick();
        voice_done = '0;
        check("done_idle", voice_busy, 3'b011);
        check("note2_held", note_to_load[2*NW +: NW], 17);

        // play=0 blocks acceptance
        play = 1'b0; ev.ev_valid = 1'b1; ev.ev_note = 6'd33;
        #1 check("pause_ready", ev.ev_ready, 0);
        tick();
        check("pause_noload", load_new_note, 0);
        ev.ev_valid = 1'b0; play = 1'b1;

        // Advance of 3 beats; beat on the acceptance edge is not counted
        ev.ev_valid = 1'b1; ev.ev_advance = 1'b1; ev.ev_duration = 6'd3; beat = 1'b1;
        #1 check("adv_ready", ev.ev_ready, 1);
        tick();
        ev.ev_valid = 1'b0; beat = 1'b0;
        check("adv_enter", ev.ev_ready, 0);
        for (int b = 0; b < 3; b++) begin
            repeat (7) tick();
            beat = 1'b1;
            #1 check("adv3_hold", ev.ev_ready, 0);
            tick();
            beat = 1'b0;
        end
        check("adv3_done", ev.ev_ready, 1);

        // Zero-length advance does not stall
        ev.ev_valid = 1'b1; ev.ev_duration = 6'd0;
        #1 check("adv0_ready", ev.ev_ready, 1);
        tick();
        check("adv0_after", ev.ev_ready, 1);
        ev.ev_valid = 1'b0;

        // Advance of 2 with two beats lost while paused
        ev.ev_valid = 1'b1; ev.ev_duration = 6'd2;
        tick();
        ev.ev_valid = 1'b0; play = 1'b0;
        for (int b = 0; b < 2; b++) begin
            repeat (3) tick();
            beat = 1'b1;
            tick();
            beat = 1'b0;
        end
        play = 1'b1;
        #1 check("paused_beats", ev.ev_ready, 0);
        repeat (3) tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("adv2_one", ev.ev_ready, 0);
        repeat (3) tick();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        check("adv2_done", ev.ev_ready, 1);

        // Release remaining voices
        voice_done = 3'b011;
        tick();
        voice_done = '0;
        check("all_free", voice_busy, 0);
        check("all_idle", all_idle, 1);

        // Reset in the middle of an advance
        ev.ev_valid = 1'b1; ev.ev_duration = 6'd5;
        tick();
        ev.ev_valid = 1'b0;
        check("adv5_hold", ev.ev_ready, 0);
        #2 reset = 1'b0;
        #1 check("midrst_ready", ev.ev_ready, 0);
        tick();
        reset = 1'b1;
        #1 check("post_rst_ready", ev.ev_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
